// File: rtl/cache_requester.sv
// Single-word cache initiator: takes one core load/store at a time, drives the
// cache enables, bounds miss stalls with a timeout and sequences abort/recover.
`timescale 1ns/1ps
module cache_requester #(
   parameter int unsigned TIMEOUT        = 16,
   parameter int unsigned RECOVER_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_core_valid,
   input  logic        i_core_we,
   input  logic [31:0] i_core_addr,
   input  logic [31:0] i_core_wdata,
   output logic        o_core_ready,
   output logic        o_core_rvalid,
   output logic [31:0] o_core_rdata,
   output logic        o_core_wdone,
   output logic        o_core_abort,
   output logic [31:0] o_address,
   output logic [31:0] o_data,
   input  logic [31:0] i_data,
   input  logic        i_hit,
   input  logic        i_miss,
   input  logic        i_abort,
   output logic        o_rd_en,
   output logic        o_wr_en,
   output logic        o_recover,
   output logic [15:0] o_miss_count
);

   localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
   localparam logic [3:0] REC_LAST  = 4'(RECOVER_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        we_q, we_d;
   logic [7:0]  stall_q, stall_d;
   logic [3:0]  rec_q, rec_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;
   logic        rvalid_q, rvalid_d;
   logic        wdone_q, wdone_d;
   logic        abort_q, abort_d;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      we_d       = we_q;
      stall_d    = stall_q;
      rec_d      = rec_q;
      miss_cnt_d = miss_cnt_q;
      rvalid_d   = 1'b0;
      wdone_d    = 1'b0;
      abort_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_core_valid) begin
               // Misaligned requests never reach the cache; the address/data
               // registers keep the last real access so the cache bus holds.
               if (i_core_addr[1:0] != 2'b00) begin
                  abort_d = 1'b1;
               end else begin
                  addr_d  = i_core_addr;
                  wdata_d = i_core_wdata;
                  we_d    = i_core_we;
                  stall_d = '0;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (i_abort) begin
               abort_d = 1'b1;
               rec_d   = '0;
               state_d = RECOVER;
            end else if (i_miss) begin
               stall_d = stall_q + 8'd1;
               if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
               if (stall_d == TIMEOUT_W) begin
                  abort_d = 1'b1;
                  rec_d   = '0;
                  state_d = RECOVER;
               end
            end else if (i_hit) begin
               if (we_q) begin
                  wdone_d = 1'b1;
               end else begin
                  rvalid_d = 1'b1;
                  rdata_d  = i_data;
               end
               state_d = IDLE;
            end
         end
         RECOVER: begin
            if (rec_q == REC_LAST) state_d = IDLE;
            else                   rec_d   = rec_q + 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         we_q       <= 1'b0;
         stall_q    <= '0;
         rec_q      <= '0;
         miss_cnt_q <= '0;
         rvalid_q   <= 1'b0;
         wdone_q    <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         we_q       <= we_d;
         stall_q    <= stall_d;
         rec_q      <= rec_d;
         miss_cnt_q <= miss_cnt_d;
         rvalid_q   <= rvalid_d;
         wdone_q    <= wdone_d;
         abort_q    <= abort_d;
      end
   end

   // Enables decode straight from state so an async reset drops them at once.
   assign o_core_ready  = (state_q == IDLE);
   assign o_rd_en       = (state_q == ACCESS) && !we_q;
   assign o_wr_en       = (state_q == ACCESS) && we_q;
   assign o_recover     = (state_q == RECOVER);
   assign o_address     = addr_q;
   assign o_data        = wdata_q;
   assign o_core_rdata  = rdata_q;
   assign o_core_rvalid = rvalid_q;
   assign o_core_wdone  = wdone_q;
   assign o_core_abort  = abort_q;
   assign o_miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester: hand-computed vector table, reset corner cases and
// randomized requests checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_cache_requester;

   localparam int TO = 4;
   localparam int RC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_core_valid = 1'b0, i_core_we = 1'b0;
   logic [31:0] i_core_addr = '0, i_core_wdata = '0, i_data = '0;
   logic        i_hit = 1'b0, i_miss = 1'b0, i_abort = 1'b0;
   logic        o_core_ready, o_core_rvalid, o_core_wdone, o_core_abort;
   logic [31:0] o_core_rdata, o_address, o_data;
   logic        o_rd_en, o_wr_en, o_recover;
   logic [15:0] o_miss_count;

   always #5 clk = ~clk;

   cache_requester #(.TIMEOUT(TO), .RECOVER_CYCLES(RC)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_core_valid(i_core_valid), .i_core_we(i_core_we),
      .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata),
      .o_core_ready(o_core_ready), .o_core_rvalid(o_core_rvalid),
      .o_core_rdata(o_core_rdata), .o_core_wdone(o_core_wdone),
      .o_core_abort(o_core_abort), .o_address(o_address), .o_data(o_data),
      .i_data(i_data), .i_hit(i_hit), .i_miss(i_miss), .i_abort(i_abort),
      .o_rd_en(o_rd_en), .o_wr_en(o_wr_en), .o_recover(o_recover),
      .o_miss_count(o_miss_count)
   );

   int total = 0;
   int bad = 0;
   logic [31:0] cmem [logic [31:0]];   // contents of the modelled cache
   logic [31:0] rmem [logic [31:0]];   // reference model's view of memory
   int          exp_mc = 0;
   logic [31:0] exp_rd = '0;
   logic [2:0]  scr [8];               // per-cycle cache response {abort,miss,hit}
   int          scr_len = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          len;
      logic [23:0] s;
      int          kind;   // 0 rvalid, 1 wdone, 2 abort
      logic [31:0] rd;
      int          ncyc;
      int          nmiss;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [2:0] code_at(input int k);
      return (k < scr_len) ? scr[k] : 3'b001;
   endfunction

   // Outcome of one aligned request from the response script alone.
   function automatic void model(input logic we, output int kind, output int ncyc, output int nmiss);
      logic [2:0] c;
      kind = we ? 1 : 0; ncyc = 0; nmiss = 0;
      for (int k = 0; k < 64; k++) begin
         c = code_at(k);
         ncyc++;
         if (c[2]) begin kind = 2; return; end
         if (c[1]) begin
            nmiss++;
            if (nmiss == TO) begin kind = 2; return; end
         end else if (c[0]) begin
            return;
         end
      end
   endfunction

   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int kind, input logic [31:0] rd, input int ncyc, input int nmiss);
      logic [2:0] c;
      @(posedge clk); #1;
      chk("ready_idle", o_core_ready, 1);
      i_core_valid = 1'b1; i_core_we = we; i_core_addr = addr; i_core_wdata = wd;
      @(negedge clk);
      chk("pulse_one_cycle", {o_core_rvalid, o_core_wdone, o_core_abort}, 0);
      @(posedge clk); #1;
      i_core_valid = 1'b0; i_core_addr = $urandom; i_core_wdata = $urandom;
      for (int k = 0; k < ncyc; k++) begin
         c = code_at(k);
         {i_abort, i_miss, i_hit} = c;
         i_data = cmem.exists(addr) ? cmem[addr] : 32'h0;
         @(negedge clk);
         chk("rd_en", o_rd_en, !we);
         chk("wr_en", o_wr_en, we);
         chk("address", o_address, addr);
         if (we) chk("wr_data", o_data, wd);
         chk("ready_busy", o_core_ready, 0);
         chk("no_pulse_busy", {o_core_rvalid, o_core_wdone, o_core_abort}, 0);
         if (we && c == 3'b001) cmem[addr] = o_data;
         @(posedge clk); #1;
      end
      {i_abort, i_miss, i_hit} = 3'b000;
      i_data = $urandom;
      exp_mc += nmiss;
      if (kind == 0) exp_rd = rd;
      @(negedge clk);
      chk("rvalid", o_core_rvalid, kind == 0);
      chk("wdone", o_core_wdone, kind == 1);
      chk("abort", o_core_abort, kind == 2);
      chk("en_off", {o_rd_en, o_wr_en}, 0);
      chk("rdata", o_core_rdata, exp_rd);
      chk("miss_count", o_miss_count, exp_mc);
      if (kind == 2 && ncyc > 0) begin
         for (int r = 0; r < RC; r++) begin
            if (r > 0) @(negedge clk);
            chk("recover_on", o_recover, 1);
            chk("ready_recover", o_core_ready, 0);
         end
         @(negedge clk);
         chk("recover_end", o_recover, 0);
      end else begin
         chk("no_recover", o_recover, 0);
      end
      chk("ready_after", o_core_ready, 1);
   endtask

   task automatic apply_vec(input vec_t v);
      scr_len = v.len;
      for (int k = 0; k < 8; k++) scr[k] = v.s[3*k +: 3];
      run_txn(v.we, v.addr, v.wdata, v.kind, v.rd, v.ncyc, v.nmiss);
   endtask

   initial begin
      vec_t vt [12];
      int kind, ncyc, nmiss, r;
      logic we;
      logic [31:0] addr, wd, rd;

      // Script codes listed first-cycle rightmost.
      vt[0]  = '{we:0, addr:32'h10, wdata:0,            len:1, s:24'(3'b001), kind:0, rd:32'hDEADBEEF, ncyc:1, nmiss:0};
      vt[1]  = '{we:1, addr:32'h20, wdata:32'h12345678, len:1, s:24'(3'b001), kind:1, rd:0, ncyc:1, nmiss:0};
      vt[2]  = '{we:0, addr:32'h20, wdata:0,            len:1, s:24'(3'b001), kind:0, rd:32'h12345678, ncyc:1, nmiss:0};
      vt[3]  = '{we:0, addr:32'h20, wdata:0, len:4, s:24'({3'b001,3'b010,3'b010,3'b010}), kind:0, rd:32'h12345678, ncyc:4, nmiss:3};
      vt[4]  = '{we:0, addr:32'h30, wdata:0, len:4, s:24'({3'b010,3'b010,3'b010,3'b010}), kind:2, rd:0, ncyc:4, nmiss:4};
      vt[5]  = '{we:0, addr:32'h13, wdata:0, len:0, s:24'(0), kind:2, rd:0, ncyc:0, nmiss:0};
      vt[6]  = '{we:1, addr:32'h24, wdata:32'hAABBCCDD, len:4, s:24'({3'b100,3'b010,3'b000,3'b000}), kind:2, rd:0, ncyc:4, nmiss:1};
      vt[7]  = '{we:1, addr:32'h24, wdata:32'h55, len:6,
                 s:24'({3'b001,3'b000,3'b010,3'b010,3'b000,3'b010}), kind:1, rd:0, ncyc:6, nmiss:3};
      vt[8]  = '{we:0, addr:32'h24, wdata:0, len:3, s:24'({3'b101,3'b011,3'b011}), kind:2, rd:0, ncyc:3, nmiss:2};
      vt[9]  = '{we:0, addr:32'h24, wdata:0, len:1, s:24'(3'b001), kind:0, rd:32'h55, ncyc:1, nmiss:0};
      vt[10] = '{we:1, addr:32'h28, wdata:32'h11111111, len:1, s:24'(3'b111), kind:2, rd:0, ncyc:1, nmiss:0};
      vt[11] = '{we:0, addr:32'h20, wdata:0, len:6,
                 s:24'({3'b001,3'b010,3'b000,3'b010,3'b010,3'b000}), kind:0, rd:32'h12345678, ncyc:6, nmiss:3};

      cmem[32'h10] = 32'hDEADBEEF;

      // Reset values, observed while reset is held.
      #12;
      chk("rst_ready", o_core_ready, 1);
      chk("rst_en", {o_rd_en, o_wr_en, o_recover}, 0);
      chk("rst_pulses", {o_core_rvalid, o_core_wdone, o_core_abort}, 0);
      chk("rst_rdata", o_core_rdata, 0);
      chk("rst_miss_count", o_miss_count, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) apply_vec(vt[i]);

      // Reset asserted mid-access: enables drop immediately, no completion.
      @(posedge clk); #1;
      i_core_valid = 1'b1; i_core_we = 1'b0; i_core_addr = 32'h10;
      @(posedge clk); #1;
      i_core_valid = 1'b0; i_miss = 1'b1;
      @(negedge clk);
      chk("mid_rst_rd_pre", o_rd_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_en", {o_rd_en, o_wr_en, o_recover}, 0);
      chk("mid_rst_ready", o_core_ready, 1);
      chk("mid_rst_pulses", {o_core_rvalid, o_core_wdone, o_core_abort}, 0);
      chk("mid_rst_miss_count", o_miss_count, 0);
      chk("mid_rst_rdata", o_core_rdata, 0);
      i_miss = 1'b0;
      exp_mc = 0; exp_rd = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_pulses", {o_core_rvalid, o_core_wdone, o_core_abort}, 0);
      apply_vec(vt[0]);

      // Randomized requests against the reference model.
      rmem[32'h10] = 32'hDEADBEEF;
      for (int n = 0; n < 60; n++) begin
         we   = 1'($urandom_range(0, 1));
         addr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
         wd   = $urandom;
         if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
         scr_len = $urandom_range(0, 7);
         for (int k = 0; k < 8; k++) begin
            r = $urandom_range(0, 9);
            scr[k] = (r < 4) ? 3'b010 : (r < 6) ? 3'b000 : 3'($urandom_range(0, 7));
         end
         if (addr[1:0] != 2'b00) begin
            kind = 2; ncyc = 0; nmiss = 0;
         end else begin
            model(we, kind, ncyc, nmiss);
         end
         rd = '0;
         if (kind == 0) rd = rmem.exists(addr) ? rmem[addr] : 32'h0;
         if (kind == 1) rmem[addr] = wd;
         run_txn(we, addr, wd, kind, rd, ncyc, nmiss);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
